// File: rtl/conv_pkg.sv
// Shared geometry for the sliding-window generator and the convolution MAC:
// default scan parameters, derived sizes and the window bit-offset helper.
package conv_pkg;

  localparam int DEF_DATA_SIZE   = 32;
  localparam int DEF_KERNEL_SIZE = 5;
  localparam int DEF_KERNEL_BW   = 5;
  localparam int DEF_STRIDE      = 1;
  localparam int DEF_PIX_BW      = 8;

  localparam int LAST_TL  = ((DEF_DATA_SIZE - DEF_KERNEL_SIZE) / DEF_STRIDE) * DEF_STRIDE;
  localparam int WIN_BW   = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE * DEF_PIX_BW;
  localparam int LB_DEPTH = DEF_DATA_SIZE;

  // Top-left coordinate of the last stride-aligned window in a frame.
  function automatic int last_tl(input int data_size, input int k, input int stride);
    return ((data_size - k) / stride) * stride;
  endfunction

  // Bit offset of window element (a,b): a = row top-to-bottom, b = col left-to-right.
  function automatic int win_idx(input int a, input int b,
                                 input int k = DEF_KERNEL_SIZE,
                                 input int pix_bw = DEF_PIX_BW);
    return (a * k + b) * pix_bw;
  endfunction

endpackage

// File: rtl/conv_window_buffer_line_buffer.sv
// One image row of pixels, addressed by column. Read is combinational and
// sees the old contents during a write, so chained buffers shift rows down.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = LB_DEPTH,
  parameter int AW    = DEF_KERNEL_BW,
  parameter int DW    = DEF_PIX_BW
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= din;
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming KxK sliding-window generator: raster-order pixels in, one window
// out per stride-aligned in-bounds position, with a single output slot.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int KERNEL_BW   = DEF_KERNEL_BW,
  parameter int STRIDE      = DEF_STRIDE,
  parameter int PIX_BW      = DEF_PIX_BW
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      i_clear,
  input  logic                                      i_valid,
  input  logic [PIX_BW-1:0]                         i_pixel,
  output logic                                      i_ready,
  output logic                                      o_valid,
  input  logic                                      o_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIX_BW-1:0] o_window,
  output logic [KERNEL_BW-1:0]                      o_row,
  output logic [KERNEL_BW-1:0]                      o_col,
  output logic                                      o_last
);

  localparam int K = KERNEL_SIZE;
  localparam logic [KERNEL_BW-1:0] K_M1     = KERNEL_BW'(K - 1);
  localparam logic [KERNEL_BW-1:0] DS_M1    = KERNEL_BW'(DATA_SIZE - 1);
  localparam logic [KERNEL_BW-1:0] STEP     = KERNEL_BW'(STRIDE);
  localparam logic [KERNEL_BW-1:0] LAST_POS = KERNEL_BW'(last_tl(DATA_SIZE, K, STRIDE));

  logic [KERNEL_BW-1:0] row_cnt, col_cnt;
  logic [KERNEL_BW-1:0] top_row, top_col;
  logic                 accept, emit;
  logic [PIX_BW-1:0]    lb_in   [K-1];
  logic [PIX_BW-1:0]    lb_out  [K-1];
  logic [PIX_BW-1:0]    new_col [K];
  logic [PIX_BW-1:0]    win     [K][K];

  // Valid/ready: a transfer happens on a clock edge where valid && ready.
  // The output slot holds o_valid and its data until taken; input is accepted
  // only when the slot is empty or being emptied in the same cycle.
  assign i_ready = !o_valid || o_ready;
  assign accept  = i_valid && i_ready && !i_clear;

  assign top_row = row_cnt - K_M1;
  assign top_col = col_cnt - K_M1;
  assign emit    = (row_cnt >= K_M1) && (col_cnt >= K_M1) &&
                   ((top_row % STEP) == '0) && ((top_col % STEP) == '0);

  assign lb_in[0] = i_pixel;

  for (genvar k = 0; k < K - 1; k++) begin : g_lb
    if (k > 0) begin : g_chain
      assign lb_in[k] = lb_out[k-1];
    end
    conv_line_buffer #(
      .DEPTH (DATA_SIZE),
      .AW    (KERNEL_BW),
      .DW    (PIX_BW)
    ) u_lb (
      .clk   (clk),
      .wr_en (accept),
      .addr  (col_cnt),
      .din   (lb_in[k]),
      .dout  (lb_out[k])
    );
  end

  // Oldest row sits in the deepest buffer and lands at the top of the window.
  for (genvar a = 0; a < K - 1; a++) begin : g_col
    assign new_col[a] = lb_out[K-2-a];
  end
  assign new_col[K-1] = i_pixel;

  for (genvar a = 0; a < K; a++) begin : g_row_out
    for (genvar b = 0; b < K; b++) begin : g_col_out
      assign o_window[win_idx(a, b, K, PIX_BW) +: PIX_BW] = win[a][b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < K; a++)
        for (int b = 0; b < K; b++)
          win[a][b] <= '0;
    end else if (accept) begin
      for (int a = 0; a < K; a++) begin
        for (int b = 0; b < K - 1; b++)
          win[a][b] <= win[a][b+1];
        win[a][K-1] <= new_col[a];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      col_cnt <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_row   <= '0;
      o_col   <= '0;
    end else if (i_clear) begin
      row_cnt <= '0;
      col_cnt <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (col_cnt == DS_M1) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == DS_M1) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      if (accept && emit) begin
        o_valid <= 1'b1;
        o_row   <= top_row;
        o_col   <= top_col;
        o_last  <= (top_row == LAST_POS) && (top_col == LAST_POS);
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer on an 8x8 image with a 3x3 kernel,
// run side by side at stride 1 and stride 2 with pixel value r*8+c.
module tb_conv_window_buffer;

  localparam int DS  = 8;
  localparam int K   = 3;
  localparam int KBW = 3;
  localparam int PBW = 8;
  localparam int WW  = K * K * PBW;
  localparam int EW  = 1 + 2 * KBW + WW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_clear = 1'b0;
  logic           i_valid = 1'b0;
  logic [PBW-1:0] i_pixel = '0;
  logic           o_ready = 1'b1;

  logic           d1_i_ready, d1_o_valid, d1_o_last;
  logic [WW-1:0]  d1_o_window;
  logic [KBW-1:0] d1_o_row, d1_o_col;
  logic           d2_i_ready, d2_o_valid, d2_o_last;
  logic [WW-1:0]  d2_o_window;
  logic [KBW-1:0] d2_o_row, d2_o_col;

  int checks = 0;
  int errors = 0;
  int hs1 = 0, hs2 = 0, last1 = 0, last2 = 0;
  bit chk2 = 1'b0;
  bit rnd_ready = 1'b0;
  logic [EW-1:0] exp1_q[$];
  logic [EW-1:0] exp2_q[$];
  logic [WW-1:0] saved;

  always #5 clk = ~clk;

  conv_window_buffer #(.DATA_SIZE(DS), .KERNEL_SIZE(K), .KERNEL_BW(KBW), .STRIDE(1), .PIX_BW(PBW)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .i_pixel(i_pixel),
    .i_ready(d1_i_ready), .o_valid(d1_o_valid), .o_ready(o_ready), .o_window(d1_o_window),
    .o_row(d1_o_row), .o_col(d1_o_col), .o_last(d1_o_last)
  );

  conv_window_buffer #(.DATA_SIZE(DS), .KERNEL_SIZE(K), .KERNEL_BW(KBW), .STRIDE(2), .PIX_BW(PBW)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .i_pixel(i_pixel),
    .i_ready(d2_i_ready), .o_valid(d2_o_valid), .o_ready(o_ready), .o_window(d2_o_window),
    .o_row(d2_o_row), .o_col(d2_o_col), .o_last(d2_o_last)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected record {last, row, col, window} for the window with top-left (tr,tc).
  function automatic logic [EW-1:0] mk(input int tr, input int tc, input bit last);
    logic [WW-1:0] w;
    w = '0;
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++)
        w[(a*K+b)*PBW +: PBW] = PBW'((tr + a) * DS + tc + b);
    return {last, KBW'(tr), KBW'(tc), w};
  endfunction

  task automatic push_s1();
    for (int tr = 0; tr <= 5; tr++)
      for (int tc = 0; tc <= 5; tc++)
        exp1_q.push_back(mk(tr, tc, (tr == 5) && (tc == 5)));
  endtask

  task automatic push_s2();
    for (int tr = 0; tr <= 4; tr += 2)
      for (int tc = 0; tc <= 4; tc += 2)
        exp2_q.push_back(mk(tr, tc, (tr == 4) && (tc == 4)));
  endtask

  // One clock: sample handshakes mid-cycle, then advance to just after the edge.
  task automatic tick(output bit acc);
    if (rnd_ready) o_ready = 1'($urandom_range(0, 1));
    #1;
    acc = i_valid && d1_i_ready && !i_clear;
    if (d1_o_valid && o_ready) begin
      hs1++;
      if (d1_o_last) last1++;
      if (exp1_q.size() == 0) chk("win1_extra", 128'(1), 128'(0));
      else chk("win1", 128'({d1_o_last, d1_o_row, d1_o_col, d1_o_window}), 128'(exp1_q.pop_front()));
    end
    if (chk2 && d2_o_valid && o_ready) begin
      hs2++;
      if (d2_o_last) last2++;
      if (exp2_q.size() == 0) chk("win2_extra", 128'(1), 128'(0));
      else chk("win2", 128'({d2_o_last, d2_o_row, d2_o_col, d2_o_window}), 128'(exp2_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bit acc;
    tick(acc);
  endtask

  task automatic send_pixel(input int r, input int c);
    bit acc;
    int n;
    n = 0;
    i_valid = 1'b1;
    i_pixel = PBW'(r * DS + c);
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) chk("accept_timeout", 128'(0), 128'(1));
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input bit rnd_gap);
    for (int r = 0; r < DS; r++)
      for (int c = 0; c < DS; c++) begin
        if (rnd_gap && ($urandom_range(0, 1) == 1)) idle();
        send_pixel(r, c);
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;

    // Reset values
    #12;
    chk("rst_o_valid", 128'(d1_o_valid), 128'(0));
    chk("rst_o_last", 128'(d1_o_last), 128'(0));
    chk("rst_o_row_col", 128'({d1_o_row, d1_o_col}), 128'(0));
    chk("rst_o_window", 128'(d1_o_window), 128'(0));
    chk("rst_i_ready", 128'(d1_i_ready), 128'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-throughput frame at stride 1 and stride 2
    chk2 = 1'b1;
    push_s1();
    push_s2();
    for (int r = 0; r < DS; r++)
      for (int c = 0; c < DS; c++) begin
        send_pixel(r, c);
        if (r == 2 && c == 1) chk("early_valid", 128'(d1_o_valid), 128'(0));
        if (r == 2 && c == 2) begin
          chk("first_valid", 128'(d1_o_valid), 128'(1));
          chk("first_row_col", 128'({d1_o_row, d1_o_col}), 128'(0));
          chk("first_e00", 128'(d1_o_window[0 +: 8]), 128'(0));
          chk("first_e02", 128'(d1_o_window[16 +: 8]), 128'(2));
          chk("first_e20", 128'(d1_o_window[48 +: 8]), 128'(16));
          chk("first_e22", 128'(d1_o_window[64 +: 8]), 128'(18));
        end
        if (r == 6 && c == 6)
          chk("s2_last", 128'({d2_o_valid, d2_o_last, d2_o_row, d2_o_col}), 128'({1'b1, 1'b1, 3'd4, 3'd4}));
        if (r == 7 && c == 7)
          chk("s1_last", 128'({d1_o_last, d1_o_row, d1_o_col, d1_o_window[64 +: 8]}), 128'({1'b1, 3'd5, 3'd5, 8'd63}));
      end
    idle();
    chk("s1_count", 128'(hs1), 128'(36));
    chk("s2_count", 128'(hs2), 128'(9));
    chk("s1_last_count", 128'(last1), 128'(1));
    chk("s2_last_count", 128'(last2), 128'(1));
    chk("s1_q_empty", 128'(exp1_q.size()), 128'(0));
    chk("s2_q_empty", 128'(exp2_q.size()), 128'(0));
    chk2 = 1'b0;

    // Backpressure right after the first window
    hs1 = 0;
    push_s1();
    for (int r = 0; r < DS; r++)
      for (int c = 0; c < DS; c++) begin
        send_pixel(r, c);
        if (r == 2 && c == 2) begin
          o_ready = 1'b0;
          saved = d1_o_window;
          i_valid = 1'b1;
          i_pixel = 8'd19;
          repeat (5) begin
            tick(acc);
            chk("bp_accept", 128'(acc), 128'(0));
            chk("bp_valid", 128'(d1_o_valid), 128'(1));
            chk("bp_window", 128'(d1_o_window), 128'(saved));
          end
          i_valid = 1'b0;
          o_ready = 1'b1;
        end
      end
    idle();
    chk("bp_count", 128'(hs1), 128'(36));
    chk("bp_q_empty", 128'(exp1_q.size()), 128'(0));

    // Three back-to-back frames with random gaps and random o_ready
    hs1 = 0;
    rnd_ready = 1'b1;
    repeat (3) begin
      push_s1();
      send_frame(1'b1);
    end
    rnd_ready = 1'b0;
    o_ready = 1'b1;
    idle();
    idle();
    chk("rnd_count", 128'(hs1), 128'(108));
    chk("rnd_q_empty", 128'(exp1_q.size()), 128'(0));

    // Clear at pixel (4,3) while window (2,0) is pending
    for (int tr = 0; tr <= 1; tr++)
      for (int tc = 0; tc <= 5; tc++)
        exp1_q.push_back(mk(tr, tc, 1'b0));
    for (int r = 0; r <= 4; r++)
      for (int c = 0; c < DS; c++)
        if (r * DS + c <= 34) send_pixel(r, c);
    o_ready = 1'b0;
    chk("clr_pending", 128'({d1_o_valid, d1_o_row, d1_o_col}), 128'({1'b1, 3'd2, 3'd0}));
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_pixel = 8'd35;
    tick(acc);
    i_clear = 1'b0;
    i_valid = 1'b0;
    chk("clr_valid", 128'(d1_o_valid), 128'(0));
    chk("clr_last", 128'(d1_o_last), 128'(0));
    o_ready = 1'b1;
    push_s1();
    for (int r = 0; r < DS; r++)
      for (int c = 0; c < DS; c++) begin
        send_pixel(r, c);
        if (r == 2 && c == 1) chk("clr_early_valid", 128'(d1_o_valid), 128'(0));
        if (r == 2 && c == 2) chk("clr_first", 128'({d1_o_valid, d1_o_row, d1_o_col}), 128'({1'b1, 3'd0, 3'd0}));
      end
    idle();
    chk("clr_q_empty", 128'(exp1_q.size()), 128'(0));

    // Asynchronous reset mid-frame with a stalled window
    for (int tc = 0; tc <= 5; tc++) exp1_q.push_back(mk(0, tc, 1'b0));
    exp1_q.push_back(mk(1, 0, 1'b0));
    exp1_q.push_back(mk(1, 1, 1'b0));
    for (int r = 0; r <= 3; r++)
      for (int c = 0; c < DS; c++)
        if (r * DS + c <= 28) send_pixel(r, c);
    o_ready = 1'b0;
    chk("prerst_valid", 128'({d1_o_valid, d1_o_row, d1_o_col}), 128'({1'b1, 3'd1, 3'd2}));
    chk("prerst_q_empty", 128'(exp1_q.size()), 128'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(d1_o_valid), 128'(0));
    chk("async_rst_state", 128'({d1_o_last, d1_o_row, d1_o_col}), 128'(0));
    chk("async_rst_window", 128'(d1_o_window), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    o_ready = 1'b1;
    hs1 = 0;
    push_s1();
    send_frame(1'b0);
    idle();
    chk("rst_count", 128'(hs1), 128'(36));
    chk("rst_q_empty", 128'(exp1_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
Streaming sliding-window generator. Sits directly upstream of the convolution MAC and shares its scan geometry with the conv control unit. Accepts a DATA_SIZE x DATA_SIZE image one pixel per beat in raster order (row outer, column inner). Emits a full KERNEL_SIZE x KERNEL_SIZE window, with valid/ready handshake, for every stride-aligned in-bounds window position.

Parameters:
DATA_SIZE, 32, image width and height in pixels (square)
KERNEL_SIZE, 5, window edge K
KERNEL_BW, 5, width of row/column counters; must satisfy 2^KERNEL_BW >= DATA_SIZE
STRIDE, 1, window step in both dimensions
PIX_BW, 8, bits per pixel

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_clear  in  1  synchronous frame flush
i_valid  in  1  input pixel valid
i_pixel  in  PIX_BW  input pixel
i_ready  out  1  input can be accepted
o_valid  out  1  window valid
o_ready  in  1  downstream accepts window
o_window  out  K*K*PIX_BW  window; element (a,b), with a = row top-to-bottom and b = col left-to-right, at bits [(a*K+b)*PIX_BW +: PIX_BW]
o_row  out  KERNEL_BW  top-left row of the emitted window
o_col  out  KERNEL_BW  top-left column of the emitted window
o_last  out  1  last window of the frame

Behaviour:
- Reset values: o_valid=0, o_last=0, o_row=0, o_col=0, o_window=0, row/col counters=0. Line buffer contents are don't-care.
- i_ready = !o_valid || o_ready (combinational). Accept = i_valid && i_ready.
- Storage:
  - K-1 row line buffers, each DATA_SIZE x PIX_BW, indexed by column.
  - K x K window register array.
- On accept at pixel (r,c):
  - Window shifts one column left.
  - New right column, top to bottom, = line_buf[K-2][c] ... line_buf[0][c], i_pixel.
  - Line buffers shift: line_buf[k][c] <= line_buf[k-1][c]; line_buf[0][c] <= i_pixel.
  - Counters advance. c wraps from DATA_SIZE-1 to 0 and increments r. (DATA_SIZE-1, DATA_SIZE-1) wraps both to 0; the next frame follows with no gap.
- Window-emit condition on the accepted pixel, evaluated with the pre-increment (r,c):
  - r >= K-1 and c >= K-1
  - (r-K+1) % STRIDE == 0 and (c-K+1) % STRIDE == 0
- When the condition holds: o_valid=1 on the next edge, o_row=r-K+1, o_col=c-K+1.
- o_last=1 when o_row == o_col == LAST_TL, where LAST_TL = ((DATA_SIZE-K)/STRIDE)*STRIDE.
- Latency: one cycle from the accept edge to o_valid.
- Window columns wrapping across the row boundary are never emitted, because of the c >= K-1 gate.
- o_valid stays high, with o_window/o_row/o_col/o_last stable, until o_valid && o_ready. No input is accepted while the slot is full and o_ready=0. This guarantees window stability with no extra output register.
- Simultaneous output handshake and new emitting accept in the same cycle: o_valid stays 1 and outputs update to the new window (full throughput).
- Handshake completes with no emitting accept: o_valid clears next edge.
- i_clear has priority over accept:
  - Counters return to 0; o_valid and o_last clear next edge.
  - Window and line buffers are not cleared; stale data is masked by the r/c gate.
  - i_ready is still driven per formula, but pixels presented with i_clear are dropped.
- Reset asserted mid-frame: all state returns to reset values immediately (async). The first pixel after deassert is (0,0).
- Pixel arithmetic: none; pure data movement. Counter compares are unsigned at KERNEL_BW bits.

Decomposition:
- Package conv_pkg holds:
  - localparams LAST_TL, WIN_BW = KERNEL_SIZE*KERNEL_SIZE*PIX_BW, and LB_DEPTH = DATA_SIZE.
  - function win_idx(a,b) returning the bit offset (a*K+b)*PIX_BW, shared with the MAC.
- One natural sub-module: conv_line_buffer. It is a single-row, DATA_SIZE-deep, column-addressed read-before-write store. It is instantiated K-1 times in a generate loop, chained output to input.

Test Plan:
- DATA_SIZE=8, K=3, STRIDE=1, pixel=r*8+c, o_ready=1, i_valid=1 continuous:
  - First o_valid is the cycle after pixel (2,2).
  - That window has (0,0)=0, (0,2)=2, (2,0)=16, (2,2)=18, o_row=0, o_col=0.
  - Exactly 36 windows per frame; o_last only on window (5,5), whose element (2,2)=63.
- Same stimulus with STRIDE=2:
  - 9 windows, top-left coordinates in {0,2,4}x{0,2,4}.
  - o_last on (4,4), emitted after pixel (6,6).
  - No window with odd coordinates.
- Backpressure: hold o_ready=0 for 5 cycles after the first window.
  - i_ready=0 throughout; o_window is unchanged.
  - On release, the window sequence is identical to the no-stall run, with no loss or duplication.
- Random i_valid (50%) and random o_ready (50%) over 3 back-to-back frames:
  - Scoreboard matches the reference window list per frame.
  - Second-frame first window is (0,0) with element (0,0)=0.
- i_clear pulsed at pixel (4,3):
  - Any pending o_valid drops.
  - Restarting the frame from (0,0) yields an exact 36-window sequence, with the first window after pixel (2,2).
- rst_n asserted mid-frame, with o_valid=1 and o_ready=0:
  - o_valid=0 immediately.
  - After release, a full frame produces 36 correct windows.
